puzzle_move_engine: RTL and testbench

//  Stateful sliding-puzzle move engine: holds a ROWS x COLS board plus a goal board, applies

---
 rtl/puzzle_move_engine_pkg.sv | 25 ++
 rtl/puzzle_nbr_calc.sv | 55 +++++
 rtl/puzzle_move_engine.sv | 190 +++++++++++++++++++
 tb/tb_puzzle_move_engine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/puzzle_move_engine_pkg.sv
// Shared definitions for the sliding-puzzle move engine: default geometry,
// command op codes and FSM state encodings.
package puzzle_move_engine_pkg;

  localparam int unsigned DEF_ROWS   = 3;
  localparam int unsigned DEF_COLS   = 3;
  localparam int unsigned DEF_TILE_W = 4;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned OP_W       = 3;

  localparam logic [OP_W-1:0] OP_QUERY   = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD    = 3'd1;
  localparam logic [OP_W-1:0] OP_SETGOAL = 3'd2;
  localparam logic [OP_W-1:0] OP_UP      = 3'd3;
  localparam logic [OP_W-1:0] OP_DOWN    = 3'd4;
  localparam logic [OP_W-1:0] OP_LEFT    = 3'd5;
  localparam logic [OP_W-1:0] OP_RIGHT   = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD    = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/puzzle_nbr_calc.sv
// Combinational neighbour lookup: given the blank index and a move op, returns
// the cell the blank would move to and whether that move stays on the board.
module puzzle_nbr_calc
  import puzzle_move_engine_pkg::*;
#(
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned COLS = DEF_COLS,
  localparam int unsigned CELLS = ROWS * COLS,
  localparam int unsigned POS_W = $clog2(CELLS)
) (
  input  logic [POS_W-1:0] blank_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [POS_W-1:0] target_c_o,
  output logic             legal_c_o
);

  int unsigned p;

  // Row/column edge tests; LEFT/RIGHT never wrap into the adjacent row.
  always_comb begin
    p          = 32'(blank_i);
    target_c_o = blank_i;
    legal_c_o  = 1'b0;
    if (p < CELLS) begin
      case (op_i)
        OP_UP: begin
          if (p >= COLS) begin
            target_c_o = POS_W'(p - COLS);
            legal_c_o  = 1'b1;
          end
        end
        OP_DOWN: begin
          if (p < CELLS - COLS) begin
            target_c_o = POS_W'(p + COLS);
            legal_c_o  = 1'b1;
          end
        end
        OP_LEFT: begin
          if ((p % COLS) != 0) begin
            target_c_o = POS_W'(p - 1);
            legal_c_o  = 1'b1;
          end
        end
        OP_RIGHT: begin
          if ((p % COLS) != COLS - 1) begin
            target_c_o = POS_W'(p + 1);
            legal_c_o  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/puzzle_move_engine.sv
// Stateful sliding-puzzle engine: board/goal registers, blank-tile moves via a
// valid/ready command channel, and a registered response with solved status.
module puzzle_move_engine
  import puzzle_move_engine_pkg::*;
#(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned TILE_W = DEF_TILE_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  localparam int unsigned CELLS   = ROWS * COLS,
  localparam int unsigned POS_W   = $clog2(CELLS),
  localparam int unsigned BOARD_W = CELLS * TILE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [BOARD_W-1:0] cmd_board,
  input  logic [POS_W-1:0]   cmd_blank,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BOARD_W-1:0] rsp_board,
  output logic [POS_W-1:0]   rsp_blank,
  output logic               rsp_illegal,
  output logic               rsp_solved,
  output logic [CNT_W-1:0]   rsp_count
);

  logic [1:0]         state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [BOARD_W-1:0] arg_board_q, arg_board_d;
  logic [POS_W-1:0]   arg_blank_q, arg_blank_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic [BOARD_W-1:0] goal_q, goal_d;
  logic [POS_W-1:0]   blank_q, blank_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               illegal_q, illegal_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [BOARD_W-1:0] rsp_board_q, rsp_board_d;
  logic [POS_W-1:0]   rsp_blank_q, rsp_blank_d;
  logic               rsp_illegal_q, rsp_illegal_d;
  logic               rsp_solved_q, rsp_solved_d;
  logic [CNT_W-1:0]   rsp_count_q, rsp_count_d;

  logic [POS_W-1:0]   nbr_target;
  logic               nbr_legal;
  logic [TILE_W-1:0]  cells [CELLS];
  logic [BOARD_W-1:0] moved_board;

  puzzle_nbr_calc #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_nbr (
    .blank_i    (blank_q),
    .op_i       (op_q),
    .target_c_o (nbr_target),
    .legal_c_o  (nbr_legal)
  );

  // Cell i lives at the MSB end for i=0; swap blank and target cells.
  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    assign cells[i] = board_q[(CELLS-1-i)*TILE_W +: TILE_W];
    assign moved_board[(CELLS-1-i)*TILE_W +: TILE_W] =
      (POS_W'(i) == blank_q)    ? cells[nbr_target] :
      (POS_W'(i) == nbr_target) ? cells[blank_q]    : cells[i];
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    arg_board_d   = arg_board_q;
    arg_blank_d   = arg_blank_q;
    board_d       = board_q;
    goal_d        = goal_q;
    blank_d       = blank_q;
    count_d       = count_q;
    illegal_d     = illegal_q;
    rsp_board_d   = rsp_board_q;
    rsp_blank_d   = rsp_blank_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_solved_d  = rsp_solved_q;
    rsp_count_d   = rsp_count_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          arg_board_d = cmd_board;
          arg_blank_d = cmd_blank;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        illegal_d = 1'b0;
        case (op_q)
          OP_QUERY: ;
          OP_LOAD: begin
            if (32'(arg_blank_q) >= CELLS) begin
              illegal_d = 1'b1;
            end else begin
              board_d = arg_board_q;
              blank_d = arg_blank_q;
              count_d = '0;
            end
          end
          OP_SETGOAL: goal_d = arg_board_q;
          OP_UP, OP_DOWN, OP_LEFT, OP_RIGHT: begin
            if (nbr_legal) begin
              board_d = moved_board;
              blank_d = nbr_target;
              if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
              end
            end else begin
              illegal_d = 1'b1;
            end
          end
          default: illegal_d = 1'b1;
        endcase
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        rsp_board_d   = board_q;
        rsp_blank_d   = blank_q;
        rsp_illegal_d = illegal_q;
        rsp_solved_d  = (board_q == goal_q);
        rsp_count_d   = count_q;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_QUERY;
      arg_board_q   <= '0;
      arg_blank_q   <= '0;
      board_q       <= '0;
      goal_q        <= '0;
      blank_q       <= '0;
      count_q       <= '0;
      illegal_q     <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_board_q   <= '0;
      rsp_blank_q   <= '0;
      rsp_illegal_q <= 1'b0;
      rsp_solved_q  <= 1'b0;
      rsp_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      arg_board_q   <= arg_board_d;
      arg_blank_q   <= arg_blank_d;
      board_q       <= board_d;
      goal_q        <= goal_d;
      blank_q       <= blank_d;
      count_q       <= count_d;
      illegal_q     <= illegal_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_board_q   <= rsp_board_d;
      rsp_blank_q   <= rsp_blank_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_solved_q  <= rsp_solved_d;
      rsp_count_q   <= rsp_count_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_board   = rsp_board_q;
  assign rsp_blank   = rsp_blank_q;
  assign rsp_illegal = rsp_illegal_q;
  assign rsp_solved  = rsp_solved_q;
  assign rsp_count   = rsp_count_q;

endmodule

// File: tb/tb_puzzle_move_engine.sv
// Directed bench for puzzle_move_engine: 3x3 engine with a 16-bit counter and a
// twin with a 2-bit counter, both driven by the same command stream.
module tb_puzzle_move_engine;
  import puzzle_move_engine_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, d2_cmd_ready;
  logic [2:0]  cmd_op;
  logic [35:0] cmd_board;
  logic [3:0]  cmd_blank;
  logic        rsp_valid, rsp_ready, d2_rsp_valid;
  logic [35:0] rsp_board, d2_rsp_board;
  logic [3:0]  rsp_blank, d2_rsp_blank;
  logic        rsp_illegal, rsp_solved, d2_rsp_illegal, d2_rsp_solved;
  logic [15:0] rsp_count;
  logic [1:0]  d2_rsp_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  puzzle_move_engine u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_board(cmd_board), .cmd_blank(cmd_blank),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_board(rsp_board),
    .rsp_blank(rsp_blank), .rsp_illegal(rsp_illegal), .rsp_solved(rsp_solved),
    .rsp_count(rsp_count)
  );

  puzzle_move_engine #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(d2_cmd_ready),
    .cmd_op(cmd_op), .cmd_board(cmd_board), .cmd_blank(cmd_blank),
    .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready), .rsp_board(d2_rsp_board),
    .rsp_blank(d2_rsp_blank), .rsp_illegal(d2_rsp_illegal), .rsp_solved(d2_rsp_solved),
    .rsp_count(d2_rsp_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_rsp(input string tag, input logic [35:0] b, input logic [3:0] blk,
                         input logic ill, input logic sol, input logic [15:0] cnt);
    check({tag, ".board"},   64'(rsp_board),   64'(b));
    check({tag, ".blank"},   64'(rsp_blank),   64'(blk));
    check({tag, ".illegal"}, 64'(rsp_illegal), 64'(ill));
    check({tag, ".solved"},  64'(rsp_solved),  64'(sol));
    check({tag, ".count"},   64'(rsp_count),   64'(cnt));
  endtask

  // Issue one command; returns clocks from accept edge to rsp_valid.
  task automatic send(input string tag, input logic [2:0] op, input logic [35:0] b,
                      input logic [3:0] blk, output int lat);
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".ready"}, 64'(cmd_ready), 64'd1);
    cmd_op = op; cmd_board = b; cmd_blank = blk; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // Plain command: latency must be 2, then compare response and release it.
  task automatic cmd(input string tag, input logic [2:0] op, input logic [35:0] b,
                     input logic [3:0] blk, input logic [35:0] eb, input logic [3:0] eblk,
                     input logic ill, input logic sol, input logic [15:0] cnt);
    int lat;
    send(tag, op, b, blk, lat);
    check({tag, ".lat"}, 64'(lat), 64'd2);
    exp_rsp(tag, eb, eblk, ill, sol, cnt);
    ack();
  endtask

  localparam logic [35:0] GOAL = 36'h123456780;

  initial begin
    int lat;
    logic [35:0] held;
    logic [35:0] eb;
    logic [3:0]  eblk;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = OP_QUERY; cmd_board = '0; cmd_blank = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst.d2_cmd_ready", 64'(d2_cmd_ready), 64'd1);
    check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    exp_rsp("rst", 36'h0, 4'd0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;

    // Basic solve
    cmd("t1.goal",  OP_SETGOAL, GOAL, 4'd0, 36'h0, 4'd0, 1'b0, 1'b0, 16'd0);
    cmd("t1.load",  OP_LOAD, 36'h123456708, 4'd7, 36'h123456708, 4'd7, 1'b0, 1'b0, 16'd0);
    cmd("t1.right", OP_RIGHT, '0, '0, GOAL, 4'd8, 1'b0, 1'b1, 16'd1);

    // Edge legality
    cmd("t2.load1", OP_LOAD, 36'h103456782, 4'd1, 36'h103456782, 4'd1, 1'b0, 1'b0, 16'd0);
    cmd("t2.up",    OP_UP, '0, '0, 36'h103456782, 4'd1, 1'b1, 1'b0, 16'd0);
    cmd("t2.load3", OP_LOAD, 36'h123056784, 4'd3, 36'h123056784, 4'd3, 1'b0, 1'b0, 16'd0);
    cmd("t2.left",  OP_LEFT, '0, '0, 36'h123056784, 4'd3, 1'b1, 1'b0, 16'd0);
    cmd("t2.load5", OP_LOAD, 36'h123450786, 4'd5, 36'h123450786, 4'd5, 1'b0, 1'b0, 16'd0);
    cmd("t2.right", OP_RIGHT, '0, '0, 36'h123450786, 4'd5, 1'b1, 1'b0, 16'd0);
    cmd("t2.down",  OP_DOWN, '0, '0, GOAL, 4'd8, 1'b0, 1'b1, 16'd1);

    // Bad LOAD index and reserved op
    cmd("t3.load9", OP_LOAD, 36'hFFFFFFFFF, 4'd9, GOAL, 4'd8, 1'b1, 1'b1, 16'd1);
    cmd("t3.op7",   OP_RSVD, '0, '0, GOAL, 4'd8, 1'b1, 1'b1, 16'd1);

    // Backpressure: response held, new command ignored
    send("t4.q", OP_QUERY, '0, '0, lat);
    check("t4.lat", 64'(lat), 64'd2);
    held = rsp_board;
    check("t4.board", 64'(held), 64'(GOAL));
    cmd_op = OP_LOAD; cmd_board = 36'h0; cmd_blank = 4'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4.hold.valid", 64'(rsp_valid), 64'd1);
      check("t4.hold.ready", 64'(cmd_ready), 64'd0);
      check("t4.hold.board", 64'(rsp_board), 64'(GOAL));
    end
    cmd_valid = 1'b0;
    ack();
    cmd("t4.after", OP_QUERY, '0, '0, GOAL, 4'd8, 1'b0, 1'b1, 16'd1);

    // Counter saturation (2-bit twin)
    cmd("t5.load", OP_LOAD, GOAL, 4'd8, GOAL, 4'd8, 1'b0, 1'b1, 16'd0);
    for (int k = 1; k <= 5; k++) begin
      send("t5.mv", (k % 2 == 1) ? OP_UP : OP_DOWN, '0, '0, lat);
      check("t5.lat", 64'(lat), 64'd2);
      eb   = (k % 2 == 1) ? 36'h123450786 : GOAL;
      eblk = (k % 2 == 1) ? 4'd5 : 4'd8;
      exp_rsp("t5.mv", eb, eblk, 1'b0, (k % 2 == 0), 16'(k));
      check("t5.d2.valid",   64'(d2_rsp_valid),   64'd1);
      check("t5.d2.count",   64'(d2_rsp_count),   64'((k > 3) ? 3 : k));
      check("t5.d2.board",   64'(d2_rsp_board),   64'(eb));
      check("t5.d2.blank",   64'(d2_rsp_blank),   64'(eblk));
      check("t5.d2.illegal", 64'(d2_rsp_illegal), 64'd0);
      check("t5.d2.solved",  64'(d2_rsp_solved),  64'(k % 2 == 0));
      ack();
    end
    cmd("t5.reload", OP_LOAD, GOAL, 4'd8, GOAL, 4'd8, 1'b0, 1'b1, 16'd0);
    check("t5.d2.reload", 64'(d2_rsp_count), 64'd0);

    // Reset during EXEC aborts the command
    @(negedge clk);
    check("t6.ready", 64'(cmd_ready), 64'd1);
    cmd_op = OP_UP; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6.cmd_ready", 64'(cmd_ready), 64'd1);
    check("t6.rsp_valid", 64'(rsp_valid), 64'd0);
    exp_rsp("t6.rst", 36'h0, 4'd0, 1'b0, 1'b0, 16'd0);
    repeat (4) @(posedge clk);
    #1;
    check("t6.no_rsp", 64'(rsp_valid), 64'd0);
    cmd("t6.query", OP_QUERY, '0, '0, 36'h0, 4'd0, 1'b0, 1'b1, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
